// File: rtl/cache_admit_if.sv
// Packet stream into the admission stage and the beat/commit stream out to data_cache.
interface cache_admit_if;
    logic         in_pkt_data_wr;
    logic [133:0] in_pkt_data;
    logic [4:0]   in_free_id_count;
    logic         out_data_cache_data_wr;
    logic [133:0] out_data_cache_data;
    logic         out_data_cache_valid_wr;
    logic         out_data_cache_valid;

    modport master (
        output in_pkt_data_wr, in_pkt_data, in_free_id_count,
        input  out_data_cache_data_wr, out_data_cache_data,
        input  out_data_cache_valid_wr, out_data_cache_valid
    );

    modport slave (
        input  in_pkt_data_wr, in_pkt_data, in_free_id_count,
        output out_data_cache_data_wr, out_data_cache_data,
        output out_data_cache_valid_wr, out_data_cache_valid
    );
endinterface

// File: rtl/cache_admit.sv
// Ingress admission in front of data_cache: drops packets when IDs run short,
// repairs malformed packets and emits the valid/valid_wr commit one cycle after the closing beat.
module cache_admit #(
    parameter int MAX_BEATS      = 128,
    parameter int FREE_ID_THRESH = 2,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    cache_admit_if.slave     bus,
    output logic [CNT_W-1:0] out_good_pkt_cnt,
    output logic [CNT_W-1:0] out_drop_pkt_cnt,
    output logic [CNT_W-1:0] out_err_pkt_cnt
);
    localparam int BC_W = $clog2(MAX_BEATS + 1);
    localparam logic [4:0]      THRESH    = 5'(FREE_ID_THRESH);
    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(MAX_BEATS - 1);

    localparam logic [1:0] T_SINGLE = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_MID    = 2'b11;

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t          state, state_nxt;
    logic [BC_W-1:0] beat_cnt, beat_nxt;
    logic            fwd, commit, commit_ok;
    logic            inc_good, inc_drop, inc_err;
    logic [133:0]    fwd_data;
    logic            commit_q, commit_ok_q;

    logic [1:0]   typ;
    logic         admit;
    logic [133:0] closed_data;

    assign typ   = bus.in_pkt_data[133:132];
    assign admit = bus.in_free_id_count >= THRESH;
    // Forced close of a broken packet: tail marker, full 16 bytes, payload kept.
    assign closed_data = {T_TAIL, 4'hF, bus.in_pkt_data[127:0]};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && !(&c)) ? c + CNT_W'(1) : c;
    endfunction

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_cnt;
        fwd       = 1'b0;
        fwd_data  = bus.in_pkt_data;
        commit    = 1'b0;
        commit_ok = 1'b0;
        inc_good  = 1'b0;
        inc_drop  = 1'b0;
        inc_err   = 1'b0;
        if (bus.in_pkt_data_wr) begin
            case (state)
                IDLE: begin
                    case (typ)
                        T_HEAD: begin
                            if (admit) begin
                                fwd       = 1'b1;
                                beat_nxt  = BC_W'(1);
                                state_nxt = FWD;
                            end else begin
                                inc_drop  = 1'b1;
                                state_nxt = DROP;
                            end
                        end
                        T_SINGLE: begin
                            if (admit) begin
                                fwd       = 1'b1;
                                fwd_data  = {T_TAIL, bus.in_pkt_data[131:0]};
                                commit    = 1'b1;
                                commit_ok = 1'b1;
                                inc_good  = 1'b1;
                            end else begin
                                inc_drop  = 1'b1;
                            end
                        end
                        default: inc_err = 1'b1;
                    endcase
                end
                FWD: begin
                    fwd = 1'b1;
                    if (typ == T_TAIL) begin
                        commit    = 1'b1;
                        commit_ok = 1'b1;
                        inc_good  = 1'b1;
                        beat_nxt  = '0;
                        state_nxt = IDLE;
                    end else if (typ != T_MID || beat_cnt == LAST_BEAT) begin
                        // Missing tail or oversize: close what we have and discard it.
                        fwd_data  = closed_data;
                        commit    = 1'b1;
                        inc_err   = 1'b1;
                        beat_nxt  = '0;
                        state_nxt = DROP;
                    end else begin
                        beat_nxt  = beat_cnt + BC_W'(1);
                    end
                end
                DROP: begin
                    if (typ == T_TAIL || typ == T_SINGLE)
                        state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                       <= IDLE;
            beat_cnt                    <= '0;
            bus.out_data_cache_data_wr  <= 1'b0;
            bus.out_data_cache_data     <= '0;
            commit_q                    <= 1'b0;
            commit_ok_q                 <= 1'b0;
            bus.out_data_cache_valid_wr <= 1'b0;
            bus.out_data_cache_valid    <= 1'b0;
            out_good_pkt_cnt            <= '0;
            out_drop_pkt_cnt            <= '0;
            out_err_pkt_cnt             <= '0;
        end else begin
            state                      <= state_nxt;
            beat_cnt                   <= beat_nxt;
            bus.out_data_cache_data_wr <= fwd;
            if (fwd)
                bus.out_data_cache_data <= fwd_data;
            // Commit trails the closing beat's output by one cycle.
            commit_q                    <= commit;
            commit_ok_q                 <= commit_ok;
            bus.out_data_cache_valid_wr <= commit_q;
            bus.out_data_cache_valid    <= commit_q & commit_ok_q;
            out_good_pkt_cnt            <= sat_inc(out_good_pkt_cnt, inc_good);
            out_drop_pkt_cnt            <= sat_inc(out_drop_pkt_cnt, inc_drop);
            out_err_pkt_cnt             <= sat_inc(out_err_pkt_cnt, inc_err);
        end
    end
endmodule

// File: tb/tb_cache_admit.sv
// Directed bench for cache_admit: admission, drop, oversize, missing tail, orphan and reset cases.
module tb_cache_admit;
    localparam logic [1:0] T_SINGLE = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_MID    = 2'b11;

    logic clk;
    logic rst;
    logic [31:0] good_cnt, drop_cnt, err_cnt;
    int checks = 0;
    int errors = 0;

    cache_admit_if bus();

    cache_admit dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus.slave),
        .out_good_pkt_cnt (good_cnt),
        .out_drop_pkt_cnt (drop_cnt),
        .out_err_pkt_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [133:0] mk(input logic [1:0] t, input logic [3:0] l, input logic [127:0] p);
        return {t, l, p};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [133:0] d);
        bus.in_pkt_data_wr = wr;
        bus.in_pkt_data    = d;
    endtask

    task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic outchk(input string tag, input logic wr, input logic [133:0] d,
                          input logic vwr, input logic v);
        chk({tag, ".wr"}, 134'(bus.out_data_cache_data_wr), 134'(wr));
        if (wr)
            chk({tag, ".data"}, bus.out_data_cache_data, d);
        chk({tag, ".valid_wr"}, 134'(bus.out_data_cache_valid_wr), 134'(vwr));
        chk({tag, ".valid"}, 134'(bus.out_data_cache_valid), 134'(v));
    endtask

    task automatic cntchk(input string tag, input int g, input int dr, input int e);
        chk({tag, ".good"}, 134'(good_cnt), 134'(g));
        chk({tag, ".drop"}, 134'(drop_cnt), 134'(dr));
        chk({tag, ".err"},  134'(err_cnt),  134'(e));
    endtask

    initial begin
        logic [133:0] b [4];
        logic [133:0] x;
        logic [1:0]   t;

        rst = 1'b1;
        bus.in_free_id_count = 5'd0;
        drive(1'b0, '0);
        tick();
        tick();
        outchk("reset", 1'b0, '0, 1'b0, 1'b0);
        chk("reset.data", bus.out_data_cache_data, '0);
        cntchk("reset", 0, 0, 0);
        rst = 1'b0;
        tick();

        // 4-beat packet, plenty of IDs
        bus.in_free_id_count = 5'd5;
        b[0] = mk(T_HEAD, 4'h0, 128'h1111_0000);
        b[1] = mk(T_MID,  4'h0, 128'h1111_0001);
        b[2] = mk(T_MID,  4'h0, 128'h1111_0002);
        b[3] = mk(T_TAIL, 4'h9, 128'h1111_0003);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, b[i]);
            tick();
            outchk("good4", 1'b1, b[i], 1'b0, 1'b0);
        end
        drive(1'b0, '0);
        tick();
        outchk("good4.commit", 1'b0, '0, 1'b1, 1'b1);
        tick();
        outchk("good4.after", 1'b0, '0, 1'b0, 1'b0);
        cntchk("good4", 1, 0, 0);

        // Same packet with too few IDs
        bus.in_free_id_count = 5'd1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, b[i]);
            tick();
            outchk("lowid", 1'b0, '0, 1'b0, 1'b0);
        end
        drive(1'b0, '0);
        tick();
        outchk("lowid.nocommit", 1'b0, '0, 1'b0, 1'b0);
        cntchk("lowid", 1, 1, 0);

        // Exactly at the threshold: admitted
        bus.in_free_id_count = 5'd2;
        drive(1'b1, b[0]);
        tick();
        outchk("thresh.head", 1'b1, b[0], 1'b0, 1'b0);
        drive(1'b1, b[3]);
        tick();
        outchk("thresh.tail", 1'b1, b[3], 1'b0, 1'b0);
        drive(1'b0, '0);
        tick();
        outchk("thresh.commit", 1'b0, '0, 1'b1, 1'b1);
        cntchk("thresh", 2, 1, 0);

        // 130-beat packet: truncated after 128 beats
        bus.in_free_id_count = 5'd5;
        for (int i = 0; i < 130; i++) begin
            t = (i == 0) ? T_HEAD : (i == 129) ? T_TAIL : T_MID;
            x = mk(t, 4'h7, 128'hA000 + 128'(i));
            drive(1'b1, x);
            tick();
            if (i < 127)
                outchk("ovs.fwd", 1'b1, x, 1'b0, 1'b0);
            else if (i == 127)
                outchk("ovs.trunc", 1'b1, mk(T_TAIL, 4'hF, 128'hA000 + 128'd127), 1'b0, 1'b0);
            else
                outchk("ovs.swallow", 1'b0, '0, i == 128, 1'b0);
        end
        drive(1'b0, '0);
        tick();
        outchk("ovs.idle", 1'b0, '0, 1'b0, 1'b0);
        cntchk("ovs", 2, 1, 1);

        // Head, middle, then a new head: synthetic tail
        b[0] = mk(T_HEAD, 4'h0, 128'hB001);
        b[1] = mk(T_MID,  4'h0, 128'hB002);
        b[2] = mk(T_HEAD, 4'h3, 128'hB003);
        drive(1'b1, b[0]);
        tick();
        outchk("mt.head", 1'b1, b[0], 1'b0, 1'b0);
        drive(1'b1, b[1]);
        tick();
        outchk("mt.mid", 1'b1, b[1], 1'b0, 1'b0);
        drive(1'b1, b[2]);
        tick();
        outchk("mt.synth", 1'b1, mk(T_TAIL, 4'hF, 128'hB003), 1'b0, 1'b0);
        drive(1'b1, mk(T_MID, 4'h0, 128'hB004));
        tick();
        outchk("mt.commit", 1'b0, '0, 1'b1, 1'b0);
        drive(1'b1, mk(T_TAIL, 4'h2, 128'hB005));
        tick();
        outchk("mt.droptail", 1'b0, '0, 1'b0, 1'b0);
        drive(1'b0, '0);
        tick();
        cntchk("mt", 2, 1, 2);

        // Orphan tail, then single-beat packet
        bus.in_free_id_count = 5'd3;
        drive(1'b1, mk(T_TAIL, 4'h3, 128'hC001));
        tick();
        outchk("orphan", 1'b0, '0, 1'b0, 1'b0);
        drive(1'b1, mk(T_SINGLE, 4'h5, 128'hC002));
        tick();
        outchk("single", 1'b1, mk(T_TAIL, 4'h5, 128'hC002), 1'b0, 1'b0);
        drive(1'b0, '0);
        tick();
        outchk("single.commit", 1'b0, '0, 1'b1, 1'b1);
        cntchk("single", 3, 1, 3);

        // Reset in the middle of a packet
        bus.in_free_id_count = 5'd5;
        b[0] = mk(T_HEAD, 4'h0, 128'hD001);
        b[1] = mk(T_MID,  4'h0, 128'hD002);
        drive(1'b1, b[0]);
        tick();
        outchk("rstmid.head", 1'b1, b[0], 1'b0, 1'b0);
        drive(1'b1, b[1]);
        tick();
        outchk("rstmid.mid", 1'b1, b[1], 1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b0, '0);
        #1;
        outchk("rstmid.async", 1'b0, '0, 1'b0, 1'b0);
        cntchk("rstmid.async", 0, 0, 0);
        tick();
        rst = 1'b0;
        tick();
        outchk("rstmid.nocommit", 1'b0, '0, 1'b0, 1'b0);
        b[2] = mk(T_HEAD, 4'h0, 128'hE001);
        b[3] = mk(T_TAIL, 4'hF, 128'hE002);
        drive(1'b1, b[2]);
        tick();
        outchk("post.head", 1'b1, b[2], 1'b0, 1'b0);
        drive(1'b1, b[3]);
        tick();
        outchk("post.tail", 1'b1, b[3], 1'b0, 1'b0);
        drive(1'b0, '0);
        tick();
        outchk("post.commit", 1'b0, '0, 1'b1, 1'b1);
        cntchk("post", 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_admit.md
Name: cache_admit

Overview:
- Ingress admission stage directly upstream of data_cache.
- Takes the 134-bit packet stream from the port receive logic and forwards it to data_cache one cycle later.
- Whole packets are dropped when data_cache has too few free packet IDs.
- Malformed packets are truncated or discarded, and each forwarded packet is closed with the valid/valid_wr commit pulse that data_cache expects.

Parameters:
- MAX_BEATS, 128, maximum beats per packet (128 x 16 B = 2048 B); a packet with more beats is truncated.
- FREE_ID_THRESH, 2, minimum in_free_id_count needed to admit a packet (covers the feedback lag of the ID count).
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- in_pkt_data_wr  in  1  input beat strobe.
- in_pkt_data  in  134  input beat. [133:132] = 01 head, 11 middle, 10 tail, 00 single-beat packet. [131:128] = valid bytes minus 1, meaningful on tail only. [127:0] = payload.
- in_free_id_count  in  5  free IDs, driven from data_cache out_data_cache_ID_count.
- out_data_cache_data_wr  out  1  to data_cache in_data_cache_data_wr.
- out_data_cache_data  out  134  to data_cache in_data_cache_data.
- out_data_cache_valid_wr  out  1  packet commit strobe.
- out_data_cache_valid  out  1  1 = keep packet, 0 = discard packet.
- out_good_pkt_cnt  out  CNT_W  packets committed with valid=1.
- out_drop_pkt_cnt  out  CNT_W  packets dropped for lack of IDs.
- out_err_pkt_cnt  out  CNT_W  malformed packets (orphan, aborted, oversize).

Behaviour:
- Reset: all outputs and counters are 0; state = IDLE; beat counter = 0. Reset asserted mid-packet abandons the packet with no commit pulse.
- Latency: every forwarded beat appears on out_data_cache_data/_wr exactly 1 cycle after input, registered. No backpressure; input may be valid every cycle.
- States: IDLE, FWD, DROP.
- IDLE, head beat:
  - If in_free_id_count >= FREE_ID_THRESH: forward the beat, beat_cnt = 1, go to FWD.
  - Otherwise: do not forward, drop_cnt += 1, go to DROP.
- IDLE, single-beat packet (00): apply the same admission test.
  - If admitted: forward it with [133:132] rewritten to 10, commit valid=1, stay in IDLE.
  - If not admitted: drop_cnt += 1.
- IDLE, middle or tail beat (orphan): discard, err_cnt += 1, stay in IDLE.
- FWD, middle beat: forward it, beat_cnt += 1.
- FWD, tail beat: forward it, commit valid=1, good_cnt += 1, go to IDLE.
- FWD, oversize: if beat_cnt == MAX_BEATS-1 and the incoming beat is not a tail:
  - forward it with [133:132] forced to 10 and [131:128] = 1111;
  - commit valid=0, err_cnt += 1, go to DROP.
- FWD, head or 00 beat arrives (missing tail on the previous packet):
  - Emit a synthetic tail: the beat is forwarded with [133:132] = 10, [131:128] = 1111 and payload unchanged.
  - Commit valid=0 for the previous packet, err_cnt += 1, go to DROP. The new packet is not admitted.
- DROP: swallow all beats. A tail returns to IDLE. A head stays in DROP. A 00 beat returns to IDLE and is itself dropped.
- Commit timing:
  - out_data_cache_valid_wr pulses for 1 cycle, on the cycle after the closing beat's out_data_cache_data_wr.
  - out_data_cache_valid is held with it.
  - It is 0 on all other cycles.
- Counter arithmetic: counters saturate at all-ones and do not wrap. beat_cnt is ceil(log2(MAX_BEATS+1)) bits.
- Admission is evaluated on the head cycle only. Changes to in_free_id_count mid-packet are ignored.

Test Plan:
- 4-beat packet (01, 11, 11, 10) with in_free_id_count = 5 -> 4 output beats each 1 cycle later, identical. valid_wr = 1 and valid = 1 at cycle T+5. good_cnt = 1.
- Same packet with in_free_id_count = 1 -> no output beats, no commit. drop_cnt = 1. A following packet with count = 2 is forwarded.
- 130-beat packet (head + 128 middle + tail) -> 128 beats out, beat 128 rewritten to tail/1111, commit valid = 0. Remaining 2 beats swallowed. err_cnt = 1.
- Head, middle, then a new head -> third beat forwarded as tail/1111, commit valid = 0, err_cnt = 1. The new packet and its beats are dropped until its tail.
- Orphan tail in IDLE, then a single-beat 00 packet with count = 3 -> orphan discarded (err_cnt = 1). The 00 beat goes out as 10 and commits valid = 1.
- rst asserted on beat 2 of 4, released, then a good packet -> outputs are 0 immediately with no commit. The next packet is forwarded normally with good_cnt = 1.
